// File: rtl/gcm_pkg.sv
// -----------------------------------------------------------------------------
// gcm_pkg
// Shared constants and types for the AES-GCM side-band datapath.
//   GCM_TEXT_W       : width of one side-band entry (plaintext + tag/control)
//   GCM_BYPASS_DEPTH : register stages matching the key-stream pipeline latency
//   gcm_text_t       : one side-band entry
// -----------------------------------------------------------------------------
package gcm_pkg;

    localparam int GCM_TEXT_W       = 289;
    localparam int GCM_BYPASS_DEPTH = 15;

    typedef logic [GCM_TEXT_W-1:0] gcm_text_t;

endpackage

// File: rtl/gcm_bypass_pipe_chk.sv
// -----------------------------------------------------------------------------
// gcm_bypass_pipe_chk
// Assertion checker for the bypass pipe occupancy counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_count    : current occupancy
//   i_accept   : upstream handshake this cycle
//   i_emit     : downstream handshake this cycle
//   i_flush    : synchronous flush this cycle
// -----------------------------------------------------------------------------
module gcm_bypass_pipe_chk #(
    parameter int DEPTH = 15,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input logic             clk,
    input logic             rst_n,
    input logic [CNT_W-1:0] i_count,
    input logic             i_accept,
    input logic             i_emit,
    input logic             i_flush
);

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        i_count <= CNT_W'(DEPTH));

    // A lone emit on an empty pipe would wrap the count below zero.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (i_emit && !i_accept && !i_flush) |-> (i_count != {CNT_W{1'b0}}));

    // A lone accept on a full pipe would push the count past DEPTH.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (i_accept && !i_emit && !i_flush) |-> (i_count != CNT_W'(DEPTH)));

endmodule

// File: rtl/gcm_bypass_stage.sv
// -----------------------------------------------------------------------------
// gcm_bypass_stage
// One elastic stage of the bypass delay line: a valid bit plus a data register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_flush         : synchronous clear of the valid bit (data is kept)
//   i_stage_ready   : this stage may take a new value this cycle
//   i_valid/i_data  : entry offered by the previous stage (or upstream)
//   o_valid/o_data  : registered stage contents
// -----------------------------------------------------------------------------
module gcm_bypass_stage
    import gcm_pkg::*;
#(
    parameter int WIDTH = GCM_TEXT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_stage_ready,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid bit: flush clears it; otherwise it follows the incoming valid whenever the stage may move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_stage_ready) begin
            r_valid <= i_valid;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Data register: loads only when a real entry moves in, so bubbles never toggle the wide bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= {WIDTH{1'b0}};
        end else if (i_stage_ready && i_valid && !i_flush) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/gcm_bypass_pipe.sv
// -----------------------------------------------------------------------------
// gcm_bypass_pipe
// Elastic delay line carrying side-band data alongside the AES-GCM cipher
// pipeline. Per-stage valid bits let bubbles collapse under back-pressure.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_valid/o_ready   : upstream handshake, i_text is the entry
//   i_flush           : synchronous discard of every held entry
//   o_valid/i_ready   : downstream handshake, o_text is the entry
//   o_count           : entries held; o_empty / o_full derived flags
// -----------------------------------------------------------------------------
module gcm_bypass_pipe
    import gcm_pkg::*;
#(
    parameter int WIDTH = GCM_TEXT_W,
    parameter int DEPTH = GCM_BYPASS_DEPTH,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_text,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_text,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH:0]   w_rdy;
    logic             w_accept;
    logic             w_emit;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_empty;
    logic             r_full;

    // Ready chain: a stage may move if it is empty or everything below it can move.
    always_comb begin
        w_rdy        = {(DEPTH+1){1'b0}};
        w_rdy[DEPTH] = i_ready;
        for (int k = DEPTH-1; k >= 0; k--) begin
            w_rdy[k] = !w_v[k] | w_rdy[k+1];
        end
    end

    assign o_ready  = w_rdy[0] & !i_flush;
    assign w_accept = i_valid & o_ready;
    assign w_emit   = w_v[DEPTH-1] & i_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_in_valid;
        logic [WIDTH-1:0] w_in_data;

        if (k == 0) begin : g_head
            assign w_in_valid = w_accept;
            assign w_in_data  = i_text;
        end else begin : g_body
            assign w_in_valid = w_v[k-1];
            assign w_in_data  = w_d[k-1];
        end

        gcm_bypass_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_flush       (i_flush),
            .i_stage_ready (w_rdy[k]),
            .i_valid       (w_in_valid),
            .i_data        (w_in_data),
            .o_valid       (w_v[k]),
            .o_data        (w_d[k])
        );
    end

    // Next occupancy: flush empties the pipe even if the output entry was taken that cycle.
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = {CNT_W{1'b0}};
        end else if (w_accept && !w_emit) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_emit && !w_accept) begin
            w_count_nxt = r_count - CNT_W'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Occupancy and flags are registered together so the flags never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == {CNT_W{1'b0}});
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

    assign o_valid = w_v[DEPTH-1];
    assign o_text  = w_d[DEPTH-1];
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

    gcm_bypass_pipe_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_count  (r_count),
        .i_accept (w_accept),
        .i_emit   (w_emit),
        .i_flush  (i_flush)
    );

endmodule

// File: tb/tb_gcm_bypass_pipe.sv
// -----------------------------------------------------------------------------
// tb_gcm_bypass_pipe
// Directed checks of the 15-stage, 289-bit pipe plus a randomised DEPTH=1,
// WIDTH=8 instance compared against a queue model.
// -----------------------------------------------------------------------------
module tb_gcm_bypass_pipe;
    import gcm_pkg::*;

    typedef gcm_text_t w_t;
    localparam int DA = GCM_BYPASS_DEPTH;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_ivalid, a_oready, a_flush, a_ovalid, a_iready, a_empty, a_full;
    gcm_text_t  a_itext, a_otext;
    logic [3:0] a_count;

    logic       b_ivalid, b_oready, b_ovalid, b_iready, b_empty, b_full;
    logic [7:0] b_itext, b_otext;
    logic [0:0] b_count;

    int        total = 0;
    int        bad   = 0;
    longint    cyc_n = 0;
    gcm_text_t q_out [$];
    longint    q_emit[$];
    longint    q_acc [$];
    logic [7:0] sbq  [$];
    bit        acc;
    int        lat;
    int        nxt;

    always #5 clk = ~clk;

    gcm_bypass_pipe u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (a_ivalid),
        .o_ready (a_oready),
        .i_text  (a_itext),
        .i_flush (a_flush),
        .o_valid (a_ovalid),
        .i_ready (a_iready),
        .o_text  (a_otext),
        .o_count (a_count),
        .o_empty (a_empty),
        .o_full  (a_full)
    );

    gcm_bypass_pipe #(
        .WIDTH (8),
        .DEPTH (1)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (b_ivalid),
        .o_ready (b_oready),
        .i_text  (b_itext),
        .i_flush (1'b0),
        .o_valid (b_ovalid),
        .i_ready (b_iready),
        .o_text  (b_otext),
        .o_count (b_count),
        .o_empty (b_empty),
        .o_full  (b_full)
    );

    // Record every handshake on the wide instance with its cycle number.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rst_n && a_ovalid && a_iready) begin
            q_out.push_back(a_otext);
            q_emit.push_back(cyc_n);
        end
        if (rst_n && a_ivalid && a_oready) begin
            q_acc.push_back(cyc_n);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input gcm_text_t obs, input gcm_text_t exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_offer(input gcm_text_t t, output bit accepted);
        a_ivalid = 1'b1;
        a_itext  = t;
        #1;
        accepted = a_oready;
        tick();
    endtask

    task automatic a_idle(input int n);
        a_ivalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_q();
        q_out.delete();
        q_emit.delete();
        q_acc.delete();
    endtask

    task automatic wait_out(input int n);
        a_ivalid = 1'b0;
        for (int w = 0; w < 200 && q_out.size() < n; w++) tick();
    endtask

    task automatic check_seq(input string tag, input int first, input int n);
        chk_eq({tag, "_n"}, w_t'(q_out.size()), w_t'(n));
        for (int i = 0; i < n && i < q_out.size(); i++) begin
            chk_eq({tag, "_data"}, q_out[i], w_t'(first + i));
        end
        if (q_out.size() == n) begin
            chk_eq({tag, "_gap"}, w_t'(q_emit[n-1] - q_emit[0]), w_t'(n - 1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_ivalid = 1'b0; a_itext = '0; a_flush = 1'b0; a_iready = 1'b0;
        b_ivalid = 1'b0; b_itext = 8'h00; b_iready = 1'b0;
        tick(); tick();

        // Reset values.
        chk_eq("rst_ovalid", w_t'(a_ovalid), w_t'(0));
        chk_eq("rst_otext",  a_otext,        w_t'(0));
        chk_eq("rst_count",  w_t'(a_count),  w_t'(0));
        chk_eq("rst_empty",  w_t'(a_empty),  w_t'(1));
        chk_eq("rst_full",   w_t'(a_full),   w_t'(0));
        chk_eq("rst_oready", w_t'(a_oready), w_t'(1));
        rst_n = 1'b1;
        tick();

        // Five entries held under back-pressure, then asynchronous reset.
        for (int i = 1; i <= 5; i++) a_offer(w_t'(i), acc);
        a_idle(20);
        chk_eq("hold_count",  w_t'(a_count),  w_t'(5));
        chk_eq("hold_ovalid", w_t'(a_ovalid), w_t'(1));
        chk_eq("hold_otext",  a_otext,        w_t'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_ovalid", w_t'(a_ovalid), w_t'(0));
        chk_eq("arst_otext",  a_otext,        w_t'(0));
        chk_eq("arst_count",  w_t'(a_count),  w_t'(0));
        chk_eq("arst_empty",  w_t'(a_empty),  w_t'(1));
        chk_eq("arst_oready", w_t'(a_oready), w_t'(1));
        tick();
        rst_n = 1'b1;
        tick();

        // Latency: entry accepted at edge t is visible after edge t+DEPTH-1.
        a_iready = 1'b1;
        a_offer(w_t'(77), acc);
        a_ivalid = 1'b0;
        lat = 0;
        while (!a_ovalid && lat < 40) begin
            tick();
            lat++;
        end
        chk_eq("lat_cycles", w_t'(lat), w_t'(DA - 1));
        chk_eq("lat_otext",  a_otext,   w_t'(77));

        // Streaming 1..40 with no stall.
        a_idle(3);
        clear_q();
        for (int i = 1; i <= 40; i++) begin
            a_offer(w_t'(i), acc);
            chk_eq("stream_acc", w_t'(acc), w_t'(1));
            if (i == 30) chk_eq("stream_count", w_t'(a_count), w_t'(DA));
        end
        wait_out(40);
        check_seq("stream", 1, 40);
        if (q_emit.size() > 0 && q_acc.size() > 0) begin
            chk_eq("stream_lat", w_t'(q_emit[0] - q_acc[0]), w_t'(DA));
        end

        // Full back-pressure: 1..20 offered, exactly DEPTH accepted.
        a_idle(2);
        clear_q();
        a_iready = 1'b0;
        nxt = 1;
        for (int c = 0; c < 20; c++) begin
            a_offer(w_t'(nxt), acc);
            chk_eq("bp_ready", w_t'(acc), w_t'(c < DA));
            if (acc) nxt++;
        end
        chk_eq("bp_accepted", w_t'(nxt - 1), w_t'(DA));
        chk_eq("bp_full",     w_t'(a_full),  w_t'(1));
        chk_eq("bp_count",    w_t'(a_count), w_t'(DA));
        a_iready = 1'b1;
        for (int g = 0; g < 50 && nxt <= 20; g++) begin
            a_offer(w_t'(nxt), acc);
            if (acc) nxt++;
        end
        wait_out(20);
        check_seq("bp", 1, 20);

        // Bubble collapse: 7 parked at the output, 8..10 slide up behind it.
        a_idle(2);
        clear_q();
        a_iready = 1'b0;
        a_offer(w_t'(7), acc);
        chk_eq("bub_acc7", w_t'(acc), w_t'(1));
        a_idle(30);
        for (int v = 8; v <= 10; v++) begin
            a_offer(w_t'(v), acc);
            chk_eq("bub_acc", w_t'(acc), w_t'(1));
        end
        a_idle(20);
        chk_eq("bub_count",  w_t'(a_count),  w_t'(4));
        chk_eq("bub_oready", w_t'(a_oready), w_t'(1));
        chk_eq("bub_otext",  a_otext,        w_t'(7));
        a_iready = 1'b1;
        wait_out(4);
        check_seq("bub", 7, 4);

        // Flush with ten entries in flight; 99 offered during the flush.
        a_idle(2);
        clear_q();
        for (int i = 1; i <= 10; i++) a_offer(w_t'(200 + i), acc);
        chk_eq("fl_count_pre", w_t'(a_count), w_t'(10));
        a_ivalid = 1'b1;
        a_itext  = w_t'(99);
        a_flush  = 1'b1;
        #1;
        chk_eq("fl_oready", w_t'(a_oready), w_t'(0));
        tick();
        a_flush  = 1'b0;
        a_ivalid = 1'b0;
        chk_eq("fl_ovalid", w_t'(a_ovalid), w_t'(0));
        chk_eq("fl_count",  w_t'(a_count),  w_t'(0));
        chk_eq("fl_empty",  w_t'(a_empty),  w_t'(1));
        a_offer(w_t'(100), acc);
        wait_out(1);
        a_idle(20);
        check_seq("flush", 100, 1);
        if (q_emit.size() > 0 && q_acc.size() > 0) begin
            chk_eq("flush_lat", w_t'(q_emit[0] - q_acc[q_acc.size()-1]), w_t'(DA));
        end

        // DEPTH=1 instance: random traffic against a queue model.
        a_iready = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            b_ivalid = 1'($urandom_range(0, 1));
            b_iready = 1'($urandom_range(0, 1));
            b_itext  = 8'($urandom);
            #1;
            chk_eq("d1_count", w_t'(b_count),  w_t'(sbq.size()));
            chk_eq("d1_valid", w_t'(b_ovalid), w_t'(sbq.size() != 0));
            chk_eq("d1_ready", w_t'(b_oready), w_t'((sbq.size() == 0) || b_iready));
            if (b_ovalid && b_iready && sbq.size() != 0) begin
                chk_eq("d1_data", w_t'(b_otext), w_t'(sbq.pop_front()));
            end
            if (b_ivalid && b_oready) sbq.push_back(b_itext);
            tick();
        end
        b_ivalid = 1'b0;
        b_iready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
